// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multi-cycle MIPS core sharing one memory and one ALU across all phases.
// Moore controls are registered alongside state; FETCH/MEMRD/MEMWR stall on mem_req/mem_ready.

module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Controls that depend only on state; strobes qualified by inputs live outside this bundle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECUTE: c.alu_src_a = 1'b1;
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP:   c.pc_src    = 2'b10;
      default:  c.alu_control = ALU_ADD;
    endcase
    return c;
  endfunction

  state_t     state_q;
  state_t     next_state;
  state_t     dec_target;
  ctrl_t      ctrl_q;
  logic       illegal_dec;
  logic       legal_r;
  logic [2:0] funct_alu;

  always_comb begin
    legal_r   = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: legal_r   = 1'b0;
    endcase
  end

  always_comb begin
    dec_target  = S_FETCH;
    illegal_dec = 1'b0;
    case (op)
      OP_LW, OP_SW: dec_target = S_MEMADR;
      OP_RTYPE: begin
        if (legal_r) dec_target  = S_EXECUTE;
        else         illegal_dec = 1'b1;
      end
      OP_BEQ:  dec_target  = S_BRANCH;
      OP_ADDI: dec_target  = S_ADDIEXEC;
      OP_J:    dec_target  = S_JUMP;
      default: illegal_dec = 1'b1;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!illegal_dec)         next_state = dec_target;
        else if (HALT_ON_ILLEGAL) next_state = S_HALT;
        else                      next_state = S_FETCH;
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  // Controls are registered from next_state so they line up with state_q with no decode delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH);
    end else begin
      state_q <= next_state;
      ctrl_q  <= ctrl_for(next_state);
    end
  end

  // Strobes are gated by reset so an access in flight dies the moment reset asserts.
  assign mem_req     = reset & ctrl_q.mem_req;
  assign mem_write   = reset & ctrl_q.mem_write;
  assign reg_write   = reset & ctrl_q.reg_write;
  assign ir_write    = reset & (state_q == S_FETCH) & mem_ready;
  assign pc_en       = reset & (((state_q == S_FETCH) & mem_ready) |
                                ((state_q == S_BRANCH) & zero) |
                                (state_q == S_JUMP));
  assign illegal_instr = reset & ((state_q == S_HALT) |
                                  ((HALT_ON_ILLEGAL == 1'b0) & (state_q == S_DECODE) & illegal_dec));

  assign iord        = ctrl_q.iord;
  assign pc_src      = ctrl_q.pc_src;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = (state_q == S_EXECUTE) ? funct_alu : ctrl_q.alu_control;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: halting and non-halting instances run the same random instruction stream
// against a per-instruction cycle-sequence model.

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req_h, mem_write_h, iord_h, ir_write_h, pc_en_h;
  logic [1:0] pc_src_h, alu_src_b_h;
  logic       alu_src_a_h, reg_dst_h, mem_to_reg_h, reg_write_h, illegal_instr_h;
  logic [2:0] alu_control_h;
  logic [3:0] state_h;

  logic       mem_req_n, mem_write_n, iord_n, ir_write_n, pc_en_n;
  logic [1:0] pc_src_n, alu_src_b_n;
  logic       alu_src_a_n, reg_dst_n, mem_to_reg_n, reg_write_n, illegal_instr_n;
  logic [2:0] alu_control_n;
  logic [3:0] state_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_h), .mem_write(mem_write_h), .iord(iord_h), .ir_write(ir_write_h),
    .pc_en(pc_en_h), .pc_src(pc_src_h), .alu_src_a(alu_src_a_h), .alu_src_b(alu_src_b_h),
    .alu_control(alu_control_h), .reg_dst(reg_dst_h), .mem_to_reg(mem_to_reg_h),
    .reg_write(reg_write_h), .illegal_instr(illegal_instr_h), .state(state_h)
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_nohalt (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_n), .mem_write(mem_write_n), .iord(iord_n), .ir_write(ir_write_n),
    .pc_en(pc_en_n), .pc_src(pc_src_n), .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n),
    .alu_control(alu_control_n), .reg_dst(reg_dst_n), .mem_to_reg(mem_to_reg_n),
    .reg_write(reg_write_n), .illegal_instr(illegal_instr_n), .state(state_n)
  );

  // {state, mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_control,
  //  reg_dst, mem_to_reg, reg_write, illegal_instr}
  wire [20:0] obs_h = {state_h, mem_req_h, mem_write_h, iord_h, ir_write_h, pc_en_h, pc_src_h,
                       alu_src_a_h, alu_src_b_h, alu_control_h, reg_dst_h, mem_to_reg_h,
                       reg_write_h, illegal_instr_h};
  wire [20:0] obs_n = {state_n, mem_req_n, mem_write_n, iord_n, ir_write_n, pc_en_n, pc_src_n,
                       alu_src_a_n, alu_src_b_n, alu_control_n, reg_dst_n, mem_to_reg_n,
                       reg_write_n, illegal_instr_n};

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int iclass(input logic [5:0] o, input logic [5:0] fn);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                         fn == 6'b100101 || fn == 6'b101010) ? C_R : C_ILL;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  // Expected output word for a given state, straight from the per-state control table.
  function automatic logic [20:0] expv(input int st, input bit rdy, input bit z,
                                       input logic [5:0] fn, input bit ill);
    logic [3:0] s4;
    logic       mr, mw, io, irw, pce, a, rd, m2r, rw, il;
    logic [1:0] ps, b;
    logic [2:0] alu;
    s4 = st[3:0];
    {mr, mw, io, irw, pce, a, rd, m2r, rw, il} = '0;
    ps = 2'b00; b = 2'b00; alu = 3'b010;
    case (st)
      0:  begin mr = 1; b = 2'b01; irw = rdy; pce = rdy; end
      1:  begin b = 2'b11; il = ill; end
      2:  begin a = 1; b = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mr = 1; mw = 1; io = 1; end
      6:  begin a = 1; alu = r_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin a = 1; alu = 3'b110; ps = 2'b01; pce = z; end
      9:  begin a = 1; b = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pce = 1; end
      12: il = 1;
      default: ;
    endcase
    return {s4, mr, mw, io, irw, pce, ps, a, b, alu, rd, m2r, rw, il};
  endfunction

  function automatic logic [20:0] reset_vec();
    logic [20:0] v;
    v = expv(0, 1'b0, 1'b0, 6'd0, 1'b0);
    v[16] = 1'b0;  // mem_req forced low while reset is held
    return v;
  endfunction

  // One clock cycle: apply mem_ready, check both instances mid-cycle, advance to just past the edge.
  task automatic step2(input int sh, input int sn, input bit rdy, input bit ill_n);
    mem_ready = rdy;
    @(negedge clk);
    chk($sformatf("halt st%0d", sh), obs_h, expv(sh, rdy, zero, funct, 1'b0));
    chk($sformatf("nohalt st%0d", sn), obs_n, expv(sn, rdy, zero, funct, ill_n));
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int st, input bit rdy);
    step2(st, st, rdy, 1'b0);
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    reset = 1'b0;
    #2;
    chk("reset assert halt", obs_h, reset_vec());
    chk("reset assert nohalt", obs_n, reset_vec());
    @(posedge clk);
    #1;
    chk("reset held halt", obs_h, reset_vec());
    chk("reset held nohalt", obs_n, reset_vec());
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input bit z,
                           input int fw, input int mw, input bit abort);
    int cls;
    op = o; funct = fn; zero = z;
    cls = iclass(o, fn);
    for (int i = 0; i < fw; i++) step(0, 1'b0);
    step(0, 1'b1);
    case (cls)
      C_LW, C_SW: begin
        step(1, 1'($urandom_range(0, 1)));
        step(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin
          step((cls == C_LW) ? 3 : 5, 1'b0);
          if (abort) begin
            do_reset();
            return;
          end
        end
        step((cls == C_LW) ? 3 : 5, 1'b1);
        if (cls == C_LW) step(4, 1'($urandom_range(0, 1)));
      end
      C_R: begin
        step(1, 1'($urandom_range(0, 1)));
        step(6, 1'($urandom_range(0, 1)));
        step(7, 1'($urandom_range(0, 1)));
      end
      C_BEQ: begin
        step(1, 1'($urandom_range(0, 1)));
        step(8, 1'($urandom_range(0, 1)));
      end
      C_ADDI: begin
        step(1, 1'($urandom_range(0, 1)));
        step(9, 1'($urandom_range(0, 1)));
        step(10, 1'($urandom_range(0, 1)));
      end
      C_J: begin
        step(1, 1'($urandom_range(0, 1)));
        step(11, 1'($urandom_range(0, 1)));
      end
      default: begin
        // Halting copy parks; non-halting copy is back in FETCH waiting on memory.
        step2(1, 1, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 3; i++) step2(12, 0, 1'b0, 1'b0);
        do_reset();
      end
    endcase
  endtask

  initial begin
    logic [5:0] o, fn;
    int         c;
    reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("por halt", obs_h, reset_vec());
    chk("por nohalt", obs_n, reset_vec());
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'b100011, 6'd7, 1'b0, 0, 0, 1'b0);
    run_instr(6'b100011, 6'd0, 1'b1, 3, 1, 1'b0);
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0, 1, 0, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0, 0, 2, 1'b0);
    run_instr(6'b001000, 6'd9, 1'b0, 0, 0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b1, 0, 0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b111111, 1'b0, 1, 0, 1'b0);
    run_instr(6'b100011, 6'd0, 1'b0, 0, 3, 1'b1);

    for (int n = 0; n < 250; n++) begin
      c  = $urandom_range(0, 6);
      fn = 6'($urandom);
      case (c)
        C_LW:   o = 6'b100011;
        C_SW:   o = 6'b101011;
        C_R: begin
          o = 6'b000000;
          case ($urandom_range(0, 4))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            default: fn = 6'b101010;
          endcase
        end
        C_BEQ:  o = 6'b000100;
        C_ADDI: o = 6'b001000;
        C_J:    o = 6'b000010;
        default: begin
          o = 6'($urandom);
          if (iclass(o, fn) != C_ILL) o = 6'b111111;
        end
      endcase
      run_instr(o, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control FSM for the multi-cycle MIPS core, where one shared memory serves instruction fetch and data access and one ALU serves PC increment, branch target and execute. It decodes `op`/`funct` from the instruction register and steps the datapath through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write strobe, and it stalls on a `mem_req`/`mem_ready` handshake. It supports R-type (add, sub, and, or, slt), lw, sw, beq, addi and j; any other encoding raises `illegal_instr`.

## Interface
- `HALT_ON_ILLEGAL`, default 1: 1 = park in HALT on an illegal encoding; 0 = pulse `illegal_instr` for one cycle and return to FETCH.
- `clk`: in, 1, rising-edge clock.
- `reset`: in, 1, asynchronous, active-low. Low = state to FETCH and all strobes forced 0.
- `op`: in, 6, instruction register [31:26].
- `funct`: in, 6, instruction register [5:0].
- `zero`: in, 1, ALU zero flag.
- `mem_ready`: in, 1, memory completes the current access this cycle.
- `mem_req`: out, 1, memory access request.
- `mem_write`: out, 1, write qualifier, valid only with `mem_req`.
- `iord`: out, 1, memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`: out, 1, load the instruction register.
- `pc_en`: out, 1, PC load enable.
- `pc_src`: out, 2, PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`: out, 1, ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`: out, 2, ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control`: out, 3, ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `reg_dst`: out, 1, destination register: 0 = rt, 1 = rd.
- `mem_to_reg`: out, 1, writeback source: 0 = ALUOut, 1 = memory data.
- `reg_write`: out, 1, register file write enable.
- `illegal_instr`: out, 1, illegal encoding detected.
- `state`: out, 4, current state encoding, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11, HALT 12. Codes 13-15 go to FETCH on the next edge.
- Any output not listed for a state is 0. `alu_control` defaults to 010.
- FETCH:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00.
  - Asserts `ir_write` and `pc_en` only in the cycle `mem_ready`=1, then goes to DECODE. Otherwise it holds.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (precomputes the branch target). Next state by `op`:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXECUTE if `funct` is one of 100000/100010/100100/100101/101010, else illegal
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - any other `op` -> illegal
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Goes to FETCH.
- MEMWR: `mem_req`=1, `mem_write`=1, `iord`=1. Holds until `mem_ready`, then goes to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00. `alu_control` is decoded combinationally from `funct`: add 010, sub 110, and 000, or 001, slt 111. Goes to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_en`=`zero`. Goes to FETCH.
- ADDIEXEC: `alu_src_a`=1, `alu_src_b`=10, add. Goes to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_en`=1. Goes to FETCH.
- Illegal encoding:
  - `HALT_ON_ILLEGAL`=1: go to HALT. HALT holds `illegal_instr`=1 with all strobes 0, and is left only by reset.
  - `HALT_ON_ILLEGAL`=0: `illegal_instr`=1 in the DECODE cycle only, then go to FETCH.

## Timing
- Outputs are Moore, decoded from registered state. The exceptions are `pc_en`/`ir_write` in FETCH (qualified by `mem_ready`), `pc_en` in BRANCH (qualified by `zero`) and `alu_control` in EXECUTE (from `funct`).
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle (`mem_ready`=0 during FETCH/MEMRD/MEMWR) adds exactly 1.
- `mem_req` stays high and `iord`/`mem_write` stay stable for the whole wait.
- `pc_en` pulses exactly once per fetch, regardless of wait cycles.
- `op`/`funct` are sampled in DECODE/EXECUTE. They are stable because `ir_write` fires only in FETCH.
- Reset:
  - While `reset`=0: `state`=0. `mem_req`, `mem_write`, `ir_write`, `pc_en`, `reg_write` and `illegal_instr` are 0. Selects read as the FETCH values.
  - Reset asserted mid-access aborts the access with no further strobes.
  - On deassertion, the first FETCH request appears in the same cycle.
- `mem_ready`=1 outside FETCH/MEMRD/MEMWR is ignored.

## Test plan
- Reset release, `mem_ready` tied 1, lw (op=100011): `state` sequence 0,1,2,3,4,0. `reg_write`=1 with `mem_to_reg`=1 only in state 4. `pc_en` high exactly one cycle.
- FETCH with `mem_ready` low for 3 cycles: `mem_req`=1 for 4 cycles, `ir_write`/`pc_en` only in the 4th cycle, then DECODE.
- R-type op=0: funct=100010 gives `alu_control`=110 in EXECUTE and `reg_dst`=1 in ALUWB. funct=101010 gives 111.
- beq: with `zero`=1, `pc_en`=1 and `pc_src`=01 in BRANCH. With `zero`=0, `pc_en` stays 0. Both take 3 cycles total.
- sw with `mem_ready` delayed 2 cycles in MEMWR: `mem_write`&`mem_req` high for 3 cycles, `reg_write` never asserts, then FETCH.
- op=111111 with `HALT_ON_ILLEGAL`=1: `state`=12 and `illegal_instr` held high until reset pulled low. The same op with `HALT_ON_ILLEGAL`=0 gives a 1-cycle `illegal_instr` pulse, then `state`=0. Reset asserted during a MEMRD wait: all strobes drop immediately.
